// File: rtl/register_file_pkg.sv
// Shared CPU constants: default datapath and register-file address widths.
package register_file_pkg;

  // Default width of every data word held or moved by the register file.
  localparam int DATA_W_DEF = 32;

  // Default address width; register count is 2**ADDR_W_DEF.
  localparam int ADDR_W_DEF = 4;

  // Number of architectural register addresses for a given address width.
  function automatic int num_regs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/register_file.sv
// Register file: one write port, two combinational read ports.
// Address 0 has no storage; it always reads the externally supplied r0 value.
// Reads have no write-to-read bypass: a write becomes visible after its edge.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int NREG = num_regs(ADDR_W);

  // Storage exists only for addresses 1..NREG-1.
  logic [DATA_W-1:0] r_regs [1:NREG-1];

  // One-hot write strobe per stored register; address 0 never gets a strobe,
  // so a write to address 0 naturally falls on the floor.
  logic [NREG-1:1] w_wr_en;

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_wr_dec
      assign w_wr_en[gi] = we3 && (wa3 == ADDR_W'(gi));
    end
  endgenerate

  // Register update: reset clears every stored register and overrides any write.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NREG; i++) begin
      if (rst) begin
        r_regs[i] <= '0;
      end else if (w_wr_en[i]) begin
        r_regs[i] <= wd3;
      end
    end
  end

  // Read port 1 mux: address 0 returns r0, otherwise the stored register.
  always_comb begin
    w_rd1 = r0;
    if (ra1 != '0) begin
      w_rd1 = r_regs[ra1];
    end
  end

  // Read port 2 mux: same selection as port 1, fully independent.
  always_comb begin
    w_rd2 = r0;
    if (ra2 != '0) begin
      w_rd2 = r_regs[ra2];
    end
  end

  assign rd1 = w_rd1;
  assign rd2 = w_rd2;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read values,
// a monitor process samples both read ports and compares.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          we3;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [DW-1:0] r0;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .we3 (we3),
    .ra1 (ra1),
    .ra2 (ra2),
    .wa3 (wa3),
    .wd3 (wd3),
    .r0  (r0),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation for both read ports and ask the monitor to sample.
  task automatic expect_rd(input string nm, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2);
    exp_t e;
    e.name = nm;
    e.e1   = e1;
    e.e2   = e2;
    sb_q.push_back(e);
    ->sample_ev;
    #3;
  endtask

  // Monitor: sample shortly after each request, away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #2;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL monitor_underflow: sample requested with empty scoreboard");
      end else begin
        e = sb_q.pop_front();
        n_tests++;
        if (rd1 !== e.e1) begin
          n_fail++;
          $display("FAIL %s rd1: got %0d expected %0d", e.name, rd1, e.e1);
        end else begin
          $display("[TB] %s rd1 = %0d ok", e.name, rd1);
        end
        n_tests++;
        if (rd2 !== e.e2) begin
          n_fail++;
          $display("FAIL %s rd2: got %0d expected %0d", e.name, rd2, e.e2);
        end else begin
          $display("[TB] %s rd2 = %0d ok", e.name, rd2);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int drain;
    rst = 1'b1; we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0; r0 = '0;

    // Reset for one edge, then stored registers read zero.
    cycle();
    rst = 1'b0; ra1 = 4'd1; ra2 = 4'd15; r0 = '0;
    expect_rd("reset_state", 32'd0, 32'd0);

    // Two writes, then read both back.
    cycle();
    we3 = 1'b1; wa3 = 4'd1; wd3 = 32'd128;
    cycle();
    wa3 = 4'd2; wd3 = 32'd64;
    cycle();
    we3 = 1'b0; ra1 = 4'd1; ra2 = 4'd2;
    expect_rd("write_read", 32'd128, 32'd64);

    // Address 0 follows r0 combinationally, no edge in between.
    ra1 = 4'd0; ra2 = 4'd0; r0 = 32'd1000;
    expect_rd("addr0_r0_1000", 32'd1000, 32'd1000);
    r0 = 32'd7;
    expect_rd("addr0_r0_7", 32'd7, 32'd7);

    // Write to address 0, then a disabled write: neither changes storage.
    cycle();
    we3 = 1'b1; wa3 = 4'd0; wd3 = 32'd5;
    cycle();
    we3 = 1'b0; wa3 = 4'd3; wd3 = 32'd9;
    cycle();
    ra1 = 4'd0; ra2 = 4'd3;
    expect_rd("write0_disabled", 32'd7, 32'd0);
    ra1 = 4'd3; ra2 = 4'd1;
    expect_rd("disabled_keep", 32'd0, 32'd128);
    ra1 = 4'd2; ra2 = 4'd2;
    expect_rd("same_addr_both", 32'd64, 32'd64);

    // Read during write: old value before the edge, new value after.
    cycle();
    we3 = 1'b1; wa3 = 4'd4; wd3 = 32'd10;
    cycle();
    wd3 = 32'd20; ra1 = 4'd4; ra2 = 4'd4;
    expect_rd("rdw_before", 32'd10, 32'd10);
    cycle();
    we3 = 1'b0;
    expect_rd("rdw_after", 32'd20, 32'd20);

    // Reset wins over a simultaneous write.
    we3 = 1'b1; wa3 = 4'd5; wd3 = 32'd55;
    cycle();
    ra1 = 4'd5; ra2 = 4'd4; we3 = 1'b0;
    expect_rd("pre_reset_reg5", 32'd55, 32'd20);
    cycle();
    rst = 1'b1; we3 = 1'b1; wa3 = 4'd5; wd3 = 32'd99;
    cycle();
    rst = 1'b0; we3 = 1'b0;
    expect_rd("reset_priority", 32'd0, 32'd0);

    // Sweep: write every stored register with a distinct value, read all back.
    for (int i = 1; i < 16; i++) begin
      we3 = 1'b1; wa3 = AW'(i); wd3 = DW'(i * 17 + 3);
      cycle();
    end
    we3 = 1'b0;
    for (int i = 1; i < 16; i++) begin
      // Write-port activity with we3 low must not disturb reads.
      wa3 = AW'(i); wd3 = 32'hDEAD_BEEF;
      ra1 = AW'(i); ra2 = AW'(16 - i);
      expect_rd($sformatf("sweep_%0d", i), DW'(i * 17 + 3), DW'((16 - i) * 17 + 3));
      cycle();
    end

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    drain = 0;
    while (sb_q.size() != 0 && drain < 20) begin
      cycle();
      drain++;
    end
    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s never_sampled: got none expected %0d/%0d", e.name, e.e1, e.e2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width of every data port and register.
REQ-003 Parameter ADDR_W, default 4, SHALL set the address width; register count is 2**ADDR_W (16).
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 we3  input  1  write enable for the write port.
REQ-007 ra1  input  ADDR_W  read address, port 1.
REQ-008 ra2  input  ADDR_W  read address, port 2.
REQ-009 wa3  input  ADDR_W  write address.
REQ-010 wd3  input  DATA_W  write data.
REQ-011 r0  input  DATA_W  externally supplied value returned for address 0 (e.g. PC-derived value).
REQ-012 rd1  output  DATA_W  read data, port 1.
REQ-013 rd2  output  DATA_W  read data, port 2.

Function
REQ-014 Storage SHALL be registers 1..2**ADDR_W-1, each DATA_W bits; address 0 has no storage.
REQ-015 On a rising clk edge with rst=0 and we3=1 and wa3!=0, register[wa3] SHALL take wd3.
REQ-016 Writes with we3=0, or with wa3=0, SHALL leave all registers unchanged.
REQ-017 rd1 SHALL be combinational: r0 when ra1=0, else register[ra1]; zero read latency.
REQ-018 rd2 SHALL be combinational: r0 when ra2=0, else register[ra2]; zero read latency.
REQ-019 r0 SHALL propagate combinationally to rd1/rd2 whenever the matching read address is 0.
REQ-020 Read-during-write to the same address SHALL return the old value until the write edge, then the new value (no write-to-read bypass).
REQ-021 ra1 and ra2 MAY be equal; both ports SHALL then return the same value.
REQ-022 Read ports SHALL be independent of we3, wa3 and wd3 except via stored contents.

Reset
REQ-023 On a rising clk edge with rst=1, registers 1..2**ADDR_W-1 SHALL become 0.
REQ-024 rst SHALL take priority over a simultaneous write; the write is discarded.
REQ-025 Reset SHALL not affect read-path combinational logic: after reset rd1/rd2 read 0 for nonzero addresses and r0 for address 0.
REQ-026 No asynchronous reset path SHALL exist.

Structure
REQ-027 DATA_W and ADDR_W defaults SHALL live as constants in the shared CPU package; no typedefs are required.
REQ-028 The block SHALL be a single module with no sub-modules; register array plus two read muxes.

Verification
REQ-029 Reset: rst=1 one edge, then ra1=1, ra2=15, r0=0 -> rd1=0, rd2=0.
REQ-030 Write/read: we3=1, wa3=1, wd3=128 edge; we3=1, wa3=2, wd3=64 edge; then ra1=1, ra2=2 -> rd1=128, rd2=64.
REQ-031 Address 0: r0=1000, ra1=0, ra2=0 -> rd1=1000, rd2=1000 combinationally; change r0 to 7 -> both 7 with no edge.
REQ-032 Write to 0 / disabled write: we3=1, wa3=0, wd3=5 edge then we3=0, wa3=3, wd3=9 edge -> ra1=0 gives r0, ra1=3 gives 0.
REQ-033 Read-during-write: reg 4=10, ra1=4, we3=1, wa3=4, wd3=20 -> rd1=10 before edge, 20 after.
REQ-034 Reset priority: rst=1 with we3=1, wa3=5, wd3=99 on same edge -> register 5 reads 0.
